// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, with the
// carry held in a register between cycles. Start/busy/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | adding one chunk per cycle, down-counter tracks chunks left
// S_DONE | result registers just loaded, done pulses for this cycle
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
            $error("chunked_seq_adder: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] part_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic             chunk_cm;

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (cnt == '0);

    // One CHUNK-bit ripple built from full-adder equations; chunk_cm is the
    // carry into the chunk's top bit, which for the final chunk is the carry into the MSB.
    always_comb begin : ripple
        logic rc;
        rc       = carry;
        chunk_cm = carry;
        chunk_s  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                chunk_cm = rc;
            end
            chunk_s[i] = op_a[i] ^ op_b[i] ^ rc;
            rc         = (op_a[i] & op_b[i]) | (rc & (op_a[i] ^ op_b[i]));
        end
        chunk_co = rc;
    end

    // Partial result fills from the top; after N shifts the LSB chunk sits at bit 0.
    assign part_nxt = (part >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            part  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            cnt   <= CNT_W'(N - 1);
            part  <= '0;
        end else if (state == S_RUN) begin
            op_a  <= op_a >> CHUNK;
            op_b  <= op_b >> CHUNK;
            carry <= chunk_co;
            part  <= part_nxt;
            cnt   <= cnt - CNT_W'(1);
            if (last) begin
                sum  <= part_nxt;
                cout <= chunk_co;
                ovf  <= chunk_cm ^ chunk_co;
            end
        end
    end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: three instances (CHUNK 4, 16, 1) share operands;
// a queue-based scoreboard checks results, latency, busy length and output hold.
module tb_chunked_seq_adder;

    localparam int W = 16;
    localparam int CH[3] = '{4, 16, 1};

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           drv;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         solo;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start_v[3];
    logic         busy_o[3];
    logic         done_o[3];
    logic [W-1:0] sum_o[3];
    logic         cout_o[3];
    logic         ovf_o[3];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start_v[0] = start;
    assign start_v[1] = start && !solo;
    assign start_v[2] = start && !solo;

    chunked_seq_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]));
    chunked_seq_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]));
    chunked_seq_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_o[2]), .done(done_o[2]), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic ms, input logic mc, input int dc);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = ms ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + (W+1)'(ms ? 1'b1 : mc);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        e.drv  = dc;
        return e;
    endfunction

    // Scoreboard: pop on every done, otherwise outputs must hold their last value.
    logic [W-1:0] last_sum[3];
    logic         last_cout[3];
    logic         last_ovf[3];
    int           busy_cnt[3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                busy_cnt[i]  = 0;
                last_sum[i]  = '0;
                last_cout[i] = 1'b0;
                last_ovf[i]  = 1'b0;
            end else begin
                if (busy_o[i]) busy_cnt[i]++;
                if (done_o[i]) begin
                    if (q[i].size() == 0) begin
                        check($sformatf("spurious_done_c%0d", CH[i]), 32'(done_o[i]), 32'd0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        check($sformatf("sum_c%0d", CH[i]), 32'(sum_o[i]), 32'(e.sum));
                        check($sformatf("cout_c%0d", CH[i]), 32'(cout_o[i]), 32'(e.cout));
                        check($sformatf("ovf_c%0d", CH[i]), 32'(ovf_o[i]), 32'(e.ovf));
                        check($sformatf("latency_c%0d", CH[i]), 32'(cyc - e.drv), 32'(1 + W / CH[i]));
                        check($sformatf("busy_len_c%0d", CH[i]), 32'(busy_cnt[i]), 32'(W / CH[i]));
                    end
                    busy_cnt[i]  = 0;
                    last_sum[i]  = sum_o[i];
                    last_cout[i] = cout_o[i];
                    last_ovf[i]  = ovf_o[i];
                end else begin
                    check($sformatf("hold_c%0d", CH[i]),
                          {14'd0, ovf_o[i], cout_o[i], sum_o[i]},
                          {14'd0, last_ovf[i], last_cout[i], last_sum[i]});
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc);
        a     = ta;
        b     = tb_;
        sub   = ts;
        cin   = tc;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0 || !solo) q[i].push_back(model(ta, tb_, ts, tc, cyc));
        end
    endtask

    task automatic wait_idle();
        int pend;
        pend = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            pend = q[0].size() + q[1].size() + q[2].size();
            if (pend == 0) break;
        end
        check("drain", 32'(pend), 32'd0);
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic ts, input logic tc);
        @(negedge clk);
        drive(ta, tb_, ts, tc);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_c%0d", tag, CH[i]),
                  {13'd0, busy_o[i], done_o[i], cout_o[i] | ovf_o[i], sum_o[i]}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        solo  = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check_zero("reset");
        #20 rst_n = 1'b1;

        op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16'h7FFF, 16'h0000, 1'b0, 1'b1);
        op(16'h0005, 16'h0007, 1'b1, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b1);
        op(16'h0005, 16'h0007, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // Start during RUN must be ignored; start held in DONE chains a new op.
        solo = 1'b1;
        @(negedge clk);
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (done_o[0]) break;
        end
        check("t4_done_seen", 32'(done_o[0]), 32'd1);
        drive(16'hABCD, 16'h1234, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        q[0].delete();
        #1;
        check_zero("midrst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        solo = 1'b0;
        op(16'h0001, 16'h0001, 1'b0, 1'b0);
        check("post_rst_sum_c4", 32'(sum_o[0]), 32'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
